// File: rtl/note_seq_if.sv
// Control/table-write and voice-output bundle between the front end (master) and note_sequencer (slave).
// SEQ_TEMPO_EN adds a run-time tick length input.
interface note_seq_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NOTE_W = 7,
  parameter int unsigned DUR_W  = 4
) ();
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic                            start_in;
  logic                            stop_in;
  logic                            loop_in;
  logic [LW-1:0]                   seq_len_in;
  logic                            wr_en;
  logic [AW-1:0]                   wr_addr;
  logic [NOTE_W-1:0]               wr_note;
  logic [DUR_W-1:0]                wr_dur;
  logic                            wr_rest;
`ifdef SEQ_TEMPO_EN
  logic [31:0]                     tick_len_in;
`endif
  logic [N_CH-1:0]                 on_out;
  logic [N_CH-1:0][NOTE_W-1:0]     note_out;
  logic [AW-1:0]                   step_out;
  logic                            busy_out;
  logic                            done_out;

  modport master (
`ifdef SEQ_TEMPO_EN
    output tick_len_in,
`endif
    output start_in, stop_in, loop_in, seq_len_in,
    output wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    input  on_out, note_out, step_out, busy_out, done_out
  );

  modport slave (
`ifdef SEQ_TEMPO_EN
    input  tick_len_in,
`endif
    input  start_in, stop_in, loop_in, seq_len_in,
    input  wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    output on_out, note_out, step_out, busy_out, done_out
  );
endinterface

// File: rtl/note_sequencer.sv
// Loadable (note, duration, rest) step player feeding N_CH voices round-robin on a tick timebase.
// Optional SEQ_TEMPO_EN: tick length taken from bus.tick_len_in instead of TICK_CYCLES.
module note_sequencer #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned NOTE_W      = 7,
  parameter int unsigned DUR_W       = 4,
  parameter int unsigned TICK_CYCLES = 12_500_000
) (
  input  logic      clk,
  input  logic      rst,
  note_seq_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned PW = DUR_W + 32;

  typedef struct packed {
    logic              rest;
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } entry_t;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  entry_t                      tbl [DEPTH];
  state_t                      state;
  logic                        pend;
  logic [AW-1:0]               idx;
  logic [PW-1:0]               rem;
  logic [LW-1:0]               seq_len_q;
  logic [31:0]                 tick_len_q;
  logic [CW-1:0]               ch_ptr;
  logic [N_CH-1:0]             on_q;
  logic [N_CH-1:0][NOTE_W-1:0] note_q;
  logic [AW-1:0]               step_q;
  logic                        busy_q;
  logic                        done_q;

  logic [31:0]                 tick_src_c;
  logic [31:0]                 tick_use_c;
  logic                        len_ok_c;
  logic                        last_c;
  logic [AW-1:0]               launch_idx_c;
  entry_t                      ent_c;
  logic [DUR_W-1:0]            dur_eff_c;
  logic [PW-1:0]               prod_c;
  logic [CW-1:0]               ch_nxt_c;

  // Table survives reset; only the write strobe changes it.
  always_ff @(posedge clk) begin
    if (bus.wr_en) tbl[bus.wr_addr] <= '{rest: bus.wr_rest, dur: bus.wr_dur, note: bus.wr_note};
  end

`ifdef SEQ_TEMPO_EN
  assign tick_src_c = (bus.tick_len_in == 32'd0) ? 32'd1 : bus.tick_len_in;
`else
  assign tick_src_c = 32'(TICK_CYCLES);
`endif

  // Next-step selection and its length in clk cycles; tick length is resampled on a loop wrap.
  always_comb begin
    len_ok_c     = (bus.seq_len_in != '0) && (bus.seq_len_in <= LW'(DEPTH));
    last_c       = ((LW'(idx) + LW'(1)) == seq_len_q);
    launch_idx_c = (pend || last_c) ? '0 : idx + AW'(1);
    tick_use_c   = (!pend && last_c) ? tick_src_c : tick_len_q;
    ent_c        = tbl[launch_idx_c];
    dur_eff_c    = (ent_c.dur == '0) ? DUR_W'(1) : ent_c.dur;
    prod_c       = PW'(dur_eff_c) * PW'(tick_use_c);
    ch_nxt_c     = (ch_ptr == CW'(N_CH - 1)) ? '0 : ch_ptr + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pend       <= 1'b0;
      idx        <= '0;
      rem        <= '0;
      seq_len_q  <= '0;
      tick_len_q <= 32'(TICK_CYCLES);
      ch_ptr     <= '0;
      on_q       <= '0;
      note_q     <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.stop_in && bus.start_in && len_ok_c) begin
            state      <= S_PLAY;
            busy_q     <= 1'b1;
            pend       <= 1'b1;
            seq_len_q  <= bus.seq_len_in;
            tick_len_q <= tick_src_c;
            ch_ptr     <= '0;
            on_q       <= '0;
          end
        end
        S_PLAY: begin
          if (bus.stop_in) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            pend   <= 1'b0;
            on_q   <= '0;
          end else if (bus.start_in && len_ok_c) begin
            pend       <= 1'b1;
            seq_len_q  <= bus.seq_len_in;
            tick_len_q <= tick_src_c;
            ch_ptr     <= '0;
            on_q       <= '0;
          end else if (pend || rem == '0) begin
            if (!pend && last_c && !bus.loop_in) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
              on_q   <= '0;
              done_q <= 1'b1;
            end else begin
              // Launch: the gate moves to ch_ptr, or all gates drop for a rest.
              pend       <= 1'b0;
              tick_len_q <= tick_use_c;
              idx        <= launch_idx_c;
              step_q     <= launch_idx_c;
              rem        <= prod_c - PW'(1);
              if (ent_c.rest) begin
                on_q <= '0;
              end else begin
                on_q           <= N_CH'(1) << ch_ptr;
                note_q[ch_ptr] <= ent_c.note;
                ch_ptr         <= ch_nxt_c;
              end
            end
          end else begin
            rem <= rem - PW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.on_out   = on_q;
  assign bus.note_out = note_q;
  assign bus.step_out = step_q;
  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with N_CH=4, DEPTH=8, TICK_CYCLES=4; outputs sampled on negedge.
module tb_note_sequencer;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NOTE_W = 7;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned TICK   = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  note_seq_if #(.N_CH(N_CH), .DEPTH(DEPTH), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .N_CH(N_CH), .DEPTH(DEPTH), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_CYCLES(TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_on(input string tag, input logic [3:0] val, input int n);
    repeat (n) begin
      @(negedge clk);
      chk(tag, 32'(bus.on_out), 32'(val));
    end
  endtask

  task automatic load(input int addr, input int note, input int dur, input logic rest);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_note = 7'(note);
    bus.wr_dur  = 4'(dur);
    bus.wr_rest = rest;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_seq(input int len, input logic lp);
    bus.seq_len_in = 4'(len);
    bus.loop_in    = lp;
    bus.start_in   = 1'b1;
    @(negedge clk);
    bus.start_in   = 1'b0;
  endtask

  task automatic stop_seq();
    bus.stop_in = 1'b1;
    @(negedge clk);
    bus.stop_in = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start_in   = 1'b0;
    bus.stop_in    = 1'b0;
    bus.loop_in    = 1'b0;
    bus.seq_len_in = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_note    = '0;
    bus.wr_dur     = '0;
    bus.wr_rest    = 1'b0;
`ifdef SEQ_TEMPO_EN
    bus.tick_len_in = 32'(TICK);
`endif
    repeat (2) @(negedge clk);
    chk("rst_on", 32'(bus.on_out), 32'd0);
    chk("rst_note", 32'(bus.note_out), 32'd0);
    chk("rst_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_done", 32'(bus.done_out), 32'd0);
    rst = 1'b0;

    // 1: three notes, no loop
    load(0, 60, 1, 1'b0);
    load(1, 62, 2, 1'b0);
    load(2, 64, 1, 1'b0);
    start_seq(3, 1'b0);
    chk("t1_busy", 32'(bus.busy_out), 32'd1);
    chk("t1_on_pend", 32'(bus.on_out), 32'd0);
    expect_on("t1_s0", 4'b0001, 4);
    chk("t1_step0", 32'(bus.step_out), 32'd0);
    expect_on("t1_s1", 4'b0010, 8);
    chk("t1_step1", 32'(bus.step_out), 32'd1);
    expect_on("t1_s2", 4'b0100, 4);
    @(negedge clk);
    chk("t1_end_on", 32'(bus.on_out), 32'd0);
    chk("t1_done", 32'(bus.done_out), 32'd1);
    chk("t1_end_busy", 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(bus.done_out), 32'd0);
    chk("t1_note0", 32'(bus.note_out[0]), 32'd60);
    chk("t1_note1", 32'(bus.note_out[1]), 32'd62);
    chk("t1_note2", 32'(bus.note_out[2]), 32'd64);
    chk("t1_note3", 32'(bus.note_out[3]), 32'd0);

    // 2: five steps looping, wrap onto channel 1, then restart while playing
    for (int i = 0; i < 5; i++) load(i, 70 + i, 1, 1'b0);
    start_seq(5, 1'b1);
    expect_on("t2_s0", 4'b0001, 4);
    expect_on("t2_s1", 4'b0010, 4);
    expect_on("t2_s2", 4'b0100, 4);
    expect_on("t2_s3", 4'b1000, 4);
    expect_on("t2_s4", 4'b0001, 4);
    expect_on("t2_wrap", 4'b0010, 4);
    chk("t2_wrap_step", 32'(bus.step_out), 32'd0);
    chk("t2_wrap_note1", 32'(bus.note_out[1]), 32'd70);
    chk("t2_busy", 32'(bus.busy_out), 32'd1);
    start_seq(5, 1'b1);
    chk("t2_restart_on", 32'(bus.on_out), 32'd0);
    chk("t2_restart_busy", 32'(bus.busy_out), 32'd1);
    expect_on("t2_restart_s0", 4'b0001, 1);
    chk("t2_restart_note0", 32'(bus.note_out[0]), 32'd70);
    stop_seq();
    chk("t2_stop_on", 32'(bus.on_out), 32'd0);
    chk("t2_stop_busy", 32'(bus.busy_out), 32'd0);
    bus.loop_in = 1'b0;

    // 3: rest step keeps ch_ptr
    load(0, 50, 1, 1'b0);
    load(1, 0, 2, 1'b1);
    load(2, 52, 1, 1'b0);
    start_seq(3, 1'b0);
    expect_on("t3_s0", 4'b0001, 4);
    expect_on("t3_rest", 4'b0000, 8);
    chk("t3_rest_step", 32'(bus.step_out), 32'd1);
    expect_on("t3_s2", 4'b0010, 4);
    chk("t3_note1", 32'(bus.note_out[1]), 32'd52);
    @(negedge clk);
    chk("t3_done", 32'(bus.done_out), 32'd1);

    // 4: live writes during play, stop mid-step 2, start+stop together
    load(0, 80, 2, 1'b0);
    load(1, 81, 2, 1'b0);
    load(2, 82, 2, 1'b0);
    start_seq(3, 1'b0);
    expect_on("t4_s0a", 4'b0001, 1);
    load(0, 99, 1, 1'b0);
    load(2, 90, 2, 1'b0);
    expect_on("t4_s0b", 4'b0001, 5);
    chk("t4_note0_held", 32'(bus.note_out[0]), 32'd80);
    expect_on("t4_s1", 4'b0010, 8);
    expect_on("t4_s2", 4'b0100, 3);
    chk("t4_note2_live", 32'(bus.note_out[2]), 32'd90);
    chk("t4_step2", 32'(bus.step_out), 32'd2);
    stop_seq();
    chk("t4_stop_on", 32'(bus.on_out), 32'd0);
    chk("t4_stop_busy", 32'(bus.busy_out), 32'd0);
    chk("t4_stop_done", 32'(bus.done_out), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_done", 32'(bus.done_out), 32'd0);
    end
    bus.seq_len_in = 4'd3;
    bus.stop_in    = 1'b1;
    bus.start_in   = 1'b1;
    @(negedge clk);
    bus.stop_in    = 1'b0;
    bus.start_in   = 1'b0;
    chk("t4_both_busy", 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    chk("t4_both_busy2", 32'(bus.busy_out), 32'd0);
    chk("t4_both_on", 32'(bus.on_out), 32'd0);

    // 5: async reset mid-step, table kept
    start_seq(3, 1'b0);
    expect_on("t5_s0", 4'b0001, 4);
    expect_on("t5_s1", 4'b0010, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_on", 32'(bus.on_out), 32'd0);
    chk("t5_rst_note", 32'(bus.note_out), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy_out), 32'd0);
    chk("t5_rst_step", 32'(bus.step_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_seq(3, 1'b0);
    chk("t5_busy", 32'(bus.busy_out), 32'd1);
    expect_on("t5_r0", 4'b0001, 4);
    chk("t5_note0", 32'(bus.note_out[0]), 32'd99);
    expect_on("t5_r1", 4'b0010, 8);
    chk("t5_note1", 32'(bus.note_out[1]), 32'd81);
    expect_on("t5_r2", 4'b0100, 8);
    chk("t5_note2", 32'(bus.note_out[2]), 32'd90);
    @(negedge clk);
    chk("t5_done", 32'(bus.done_out), 32'd1);

    // 6: invalid lengths ignored; tempo override when built in
    start_seq(0, 1'b0);
    chk("t6_len0_busy", 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    chk("t6_len0_busy2", 32'(bus.busy_out), 32'd0);
    chk("t6_len0_on", 32'(bus.on_out), 32'd0);
    start_seq(9, 1'b0);
    chk("t6_len9_busy", 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    chk("t6_len9_busy2", 32'(bus.busy_out), 32'd0);
`ifdef SEQ_TEMPO_EN
    bus.tick_len_in = 32'd2;
    load(0, 40, 3, 1'b0);
    start_seq(1, 1'b0);
    expect_on("t6_tempo", 4'b0001, 6);
    @(negedge clk);
    chk("t6_tempo_off", 32'(bus.on_out), 32'd0);
    chk("t6_tempo_done", 32'(bus.done_out), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
